// File: rtl/n64_pkg.sv
// Shared types and constants for the N64 controller poller: FSM encoding,
// command/response framing and CTRL register bit positions.
package n64_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TX      = 3'd1,
        ST_RX_WAIT = 3'd2,
        ST_RX_BIT  = 3'd3,
        ST_RX_STOP = 3'd4
    } state_t;

    localparam logic [7:0] CMD_POLL  = 8'h01;
    localparam int         RESP_BITS = 32;
    localparam int         TX_BITS   = 9;

    localparam int CTRL_ENABLE  = 0;
    localparam int CTRL_VALID   = 1;
    localparam int CTRL_TIMEOUT = 2;
    localparam int CTRL_BUSY    = 3;

    function automatic logic [31:0] ctrl_word(input logic busy, input logic timeout,
                                              input logic valid, input logic enable);
        logic [31:0] w;
        w = '0;
        w[CTRL_BUSY]    = busy;
        w[CTRL_TIMEOUT] = timeout;
        w[CTRL_VALID]   = valid;
        w[CTRL_ENABLE]  = enable;
        return w;
    endfunction

endpackage

// File: rtl/n64_bit_tx.sv
// Drives one 4 us N64 bit cell on the open-drain line: '0' = 3 us low / 1 us high,
// '1' = 1 us low / 3 us high. A start on the done cycle chains cells back to back.
module n64_bit_tx #(
    parameter int US_CYCLES = 50
) (
    input  logic PCLK,
    input  logic PRESERN,
    input  logic start,
    input  logic bit_val,
    output logic drive_low,
    output logic done
);
    localparam int CELL = 4 * US_CYCLES;
    localparam int CW   = $clog2(CELL);

    localparam logic [CW-1:0] CELL_TC  = CW'(CELL - 1);
    localparam logic [CW-1:0] TAIL_ZERO = CW'(US_CYCLES);
    localparam logic [CW-1:0] TAIL_ONE  = CW'(3 * US_CYCLES);

    logic [CW-1:0] cnt;
    logic          active;
    logic          bit_q;

    always_ff @(posedge PCLK or posedge PRESERN) begin
        if (PRESERN) begin
            active <= 1'b0;
            cnt    <= '0;
            bit_q  <= 1'b0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= CELL_TC;
            bit_q  <= bit_val;
        end else if (active && cnt == '0) begin
            active <= 1'b0;
        end else if (active) begin
            cnt <= cnt - CW'(1);
        end
    end

    // cnt counts down the remaining cycles; the line is low until only the high tail is left
    assign drive_low = active && (cnt >= (bit_q ? TAIL_ONE : TAIL_ZERO));
    assign done      = active && (cnt == '0);

endmodule

// File: rtl/n64_controller_poll.sv
// APB3 slave that periodically polls an N64 controller and exposes the last 32-bit word.
//   state      | meaning
//   IDLE       | line released, waiting for poll timer wrap
//   TX         | sending 0x01 + stop bit, one cell at a time
//   RX_WAIT    | waiting for the falling edge of the next response bit
//   RX_BIT     | sampling the line 2 us after that edge
//   RX_STOP    | waiting for the stop-bit edge, then latching the word
module n64_controller_poll
    import n64_pkg::*;
#(
    parameter int          US_CYCLES   = 50,
    parameter int          POLL_PERIOD = 833333,
    parameter int          TIMEOUT_US  = 64,
    parameter logic [11:0] ADDR_DATA   = 12'h000,
    parameter logic [11:0] ADDR_CTRL   = 12'h004
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        n64_data_in,
    output logic        n64_drive_low,
    output logic        poll_done
);
    localparam int UW        = $clog2(US_CYCLES);
    localparam int TW        = $clog2(TIMEOUT_US + 1);
    localparam int PW        = $clog2(POLL_PERIOD);
    localparam int BW        = $clog2(RESP_BITS);
    localparam int XW        = $clog2(TX_BITS);
    localparam int SAMPLE_US = 2;

    localparam logic [TX_BITS-1:0] TX_FRAME = {CMD_POLL, 1'b1};

    state_t              state, state_d;
    logic [1:0]          sync_q;
    logic                rx_s, rx_prev, rx_fall;
    logic [UW-1:0]       us_cyc;
    logic [TW-1:0]       us_cnt;
    logic                us_tick, timed_out, sample_now;
    logic [PW-1:0]       poll_cnt;
    logic                poll_wrap;
    logic [TX_BITS-1:0]  tx_bits;
    logic [XW-1:0]       tx_idx;
    logic                tx_start, tx_bit_val, tx_done;
    logic [RESP_BITS-1:0] rx_shift, word;
    logic [BW-1:0]       rx_idx;
    logic                enable, valid, timeout, busy;
    logic                tmr_clr, rx_sample, set_timeout, latch;
    logic                ctrl_wr, rd_setup;
    logic                unused_bits;

    assign PREADY      = 1'b1;
    assign PSLVERR     = 1'b0;
    assign unused_bits = ^{PADDR[31:12], PWDATA[31:3], PWDATA[1]};

    // Line idles high, so the synchroniser resets to 1 to avoid a false edge
    always_ff @(posedge PCLK or posedge PRESERN) begin
        if (PRESERN) begin
            sync_q  <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], n64_data_in};
            rx_prev <= rx_s;
        end
    end
    assign rx_s    = sync_q[1];
    assign rx_fall = rx_prev & ~rx_s;

    always_ff @(posedge PCLK or posedge PRESERN) begin
        if (PRESERN) begin
            us_cyc <= UW'(US_CYCLES - 1);
            us_cnt <= '0;
        end else if (tmr_clr) begin
            us_cyc <= UW'(US_CYCLES - 1);
            us_cnt <= '0;
        end else if (us_tick) begin
            us_cyc <= UW'(US_CYCLES - 1);
            us_cnt <= us_cnt + TW'(1);
        end else begin
            us_cyc <= us_cyc - UW'(1);
        end
    end
    assign us_tick    = (us_cyc == '0);
    assign timed_out  = (us_cnt == TW'(TIMEOUT_US));
    assign sample_now = us_tick && (us_cnt == TW'(SAMPLE_US - 1));

    always_ff @(posedge PCLK or posedge PRESERN) begin
        if (PRESERN)        poll_cnt <= '0;
        else if (!enable)   poll_cnt <= '0;
        else if (poll_wrap) poll_cnt <= '0;
        else                poll_cnt <= poll_cnt + PW'(1);
    end
    assign poll_wrap = (poll_cnt == PW'(POLL_PERIOD - 1));

    assign tx_bit_val = (state == ST_TX) ? tx_bits[TX_BITS-2] : tx_bits[TX_BITS-1];

    n64_bit_tx #(.US_CYCLES(US_CYCLES)) u_bit_tx (
        .PCLK      (PCLK),
        .PRESERN   (PRESERN),
        .start     (tx_start),
        .bit_val   (tx_bit_val),
        .drive_low (n64_drive_low),
        .done      (tx_done)
    );

    always_ff @(posedge PCLK or posedge PRESERN) begin
        if (PRESERN) state <= ST_IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d     = state;
        tx_start    = 1'b0;
        tmr_clr     = 1'b0;
        rx_sample   = 1'b0;
        set_timeout = 1'b0;
        latch       = 1'b0;
        case (state)
            ST_IDLE: begin
                tmr_clr = 1'b1;
                if (enable && poll_wrap) begin
                    tx_start = 1'b1;
                    state_d  = ST_TX;
                end
            end
            ST_TX: begin
                tmr_clr = 1'b1;
                if (tx_done) begin
                    if (tx_idx == XW'(TX_BITS - 1)) state_d  = ST_RX_WAIT;
                    else                            tx_start = 1'b1;
                end
            end
            ST_RX_WAIT: begin
                if (rx_fall) begin
                    tmr_clr = 1'b1;
                    state_d = ST_RX_BIT;
                end else if (timed_out) begin
                    set_timeout = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_RX_BIT: begin
                if (sample_now) begin
                    rx_sample = 1'b1;
                    tmr_clr   = 1'b1;
                    state_d   = (rx_idx == BW'(RESP_BITS - 1)) ? ST_RX_STOP : ST_RX_WAIT;
                end
            end
            ST_RX_STOP: begin
                if (rx_fall) begin
                    latch   = 1'b1;
                    state_d = ST_IDLE;
                end else if (timed_out) begin
                    set_timeout = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy     = (state != ST_IDLE);
    assign ctrl_wr  = PSEL & PWRITE & PENABLE & (PADDR[11:0] == ADDR_CTRL);
    assign rd_setup = PSEL & ~PENABLE & ~PWRITE;

    always_ff @(posedge PCLK or posedge PRESERN) begin
        if (PRESERN) begin
            tx_bits   <= TX_FRAME;
            tx_idx    <= '0;
            rx_shift  <= '0;
            rx_idx    <= '0;
            word      <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
            enable    <= 1'b0;
            poll_done <= 1'b0;
        end else begin
            poll_done <= latch;
            if (state == ST_IDLE) begin
                tx_bits <= TX_FRAME;
                tx_idx  <= '0;
                rx_idx  <= '0;
            end else if (tx_done) begin
                tx_bits <= tx_bits << 1;
                tx_idx  <= tx_idx + XW'(1);
            end
            if (rx_sample) begin
                rx_shift <= {rx_shift[RESP_BITS-2:0], rx_s};
                rx_idx   <= rx_idx + BW'(1);
            end
            if (latch) begin
                word  <= rx_shift;
                valid <= 1'b1;
            end
            if (ctrl_wr) begin
                enable <= PWDATA[CTRL_ENABLE];
                if (PWDATA[CTRL_TIMEOUT]) timeout <= 1'b0;
            end
            // A new timeout outranks a clear issued in the same cycle
            if (set_timeout) timeout <= 1'b1;
        end
    end

    always_ff @(posedge PCLK or posedge PRESERN) begin
        if (PRESERN) begin
            PRDATA <= '0;
        end else if (rd_setup) begin
            if (PADDR[11:0] == ADDR_DATA)      PRDATA <= word;
            else if (PADDR[11:0] == ADDR_CTRL) PRDATA <= ctrl_word(busy, timeout, valid, enable);
            else                               PRDATA <= '0;
        end
    end

endmodule

// File: tb/tb_n64_controller_poll.sv
// Scoreboarded bench for n64_controller_poll: APB reads and TX pulse widths are
// checked by monitors against queues filled by the directed stimulus.
module tb_n64_controller_poll;
    localparam int US     = 50;
    localparam int PERIOD = 10000;

    logic        PCLK, PRESERN, PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic        n64_data_in, n64_drive_low, poll_done;
    logic        ctrl_low;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    int          tx_exp_q[$];
    int          cell_chk = 0;
    int          rise_cnt = 0;
    int          done_cnt = 0;
    int          long_done = 0;

    n64_controller_poll #(.US_CYCLES(US), .POLL_PERIOD(PERIOD), .TIMEOUT_US(64)) dut (
        .PCLK          (PCLK),
        .PRESERN       (PRESERN),
        .PSEL          (PSEL),
        .PENABLE       (PENABLE),
        .PWRITE        (PWRITE),
        .PADDR         (PADDR),
        .PWDATA        (PWDATA),
        .PRDATA        (PRDATA),
        .PREADY        (PREADY),
        .PSLVERR       (PSLVERR),
        .n64_data_in   (n64_data_in),
        .n64_drive_low (n64_drive_low),
        .poll_done     (poll_done)
    );

    assign n64_data_in = ~(n64_drive_low | ctrl_low);

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Read scoreboard: PRDATA is valid during the access phase
    always @(negedge PCLK) begin
        if (PSEL && PENABLE && !PWRITE) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_read: got %h expected none", PRDATA);
            end else begin
                chk(name_q.pop_front(), PRDATA, exp_q.pop_front());
            end
        end
    end

    // TX monitor: low width of each cell and rise-to-rise cell length
    logic dl_prev = 1'b0;
    int   low_len = 0;
    int   since_rise = 100000;
    always @(negedge PCLK) begin
        if (n64_drive_low && !dl_prev) begin
            rise_cnt++;
            if (cell_chk > 0 && since_rise < 1000) begin
                chk("tx_cell_len", since_rise, 200);
                cell_chk--;
            end
            since_rise = 0;
            low_len    = 0;
        end
        if (n64_drive_low) low_len++;
        if (!n64_drive_low && dl_prev && tx_exp_q.size() > 0)
            chk("tx_low_len", low_len, tx_exp_q.pop_front());
        if (since_rise < 100000) since_rise++;
        dl_prev = n64_drive_low;
    end

    logic pd_prev = 1'b0;
    always @(negedge PCLK) begin
        if (poll_done) done_cnt++;
        if (poll_done && pd_prev) long_done++;
        pd_prev = poll_done;
    end

    task automatic apb_read(input logic [11:0] a, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = {20'h0, a};
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = {20'h0, a}; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wait_tx_start(input string name);
        int n;
        n = 0;
        while (!n64_drive_low && n < PERIOD + 500) begin
            @(negedge PCLK);
            n++;
        end
        n_vec++;
        if (!n64_drive_low) begin
            n_err++;
            $display("FAIL %s: got no tx start within %0d cycles expected tx start", name, n);
        end
    endtask

    task automatic send_resp(input logic [31:0] w, input bit with_stop);
        for (int i = 31; i >= 0; i--) begin
            ctrl_low = 1'b1;
            repeat (w[i] ? US : 3 * US) @(posedge PCLK);
            ctrl_low = 1'b0;
            repeat (w[i] ? 3 * US : US) @(posedge PCLK);
        end
        if (with_stop) begin
            ctrl_low = 1'b1;
            repeat (2 * US) @(posedge PCLK);
            ctrl_low = 1'b0;
        end
    endtask

    initial begin
        int rises;
        PRESERN = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; ctrl_low = 1'b0;
        repeat (4) @(posedge PCLK);
        #1 PRESERN = 1'b0;

        chk("rst_drive_low", {31'b0, n64_drive_low}, 32'd0);
        chk("rst_poll_done", {31'b0, poll_done}, 32'd0);
        apb_read(12'h004, 32'h0, "rst_ctrl");
        apb_read(12'h000, 32'h0, "rst_data");
        apb_write(12'h000, 32'hFFFF_FFFF);
        apb_read(12'h000, 32'h0, "data_write_ignored");
        apb_read(12'h008, 32'h0, "bad_addr");

        // Reset while transmitting
        apb_write(12'h004, 32'h1);
        wait_tx_start("tx_start_before_reset");
        repeat (300) @(posedge PCLK);
        #1 PRESERN = 1'b1;
        #1 chk("reset_mid_tx_drive_low", {31'b0, n64_drive_low}, 32'd0);
        repeat (3) @(posedge PCLK);
        #1 PRESERN = 1'b0;
        apb_read(12'h004, 32'h0, "ctrl_after_reset");
        rises = rise_cnt;
        repeat (PERIOD + 500) @(posedge PCLK);
        chk("no_poll_when_disabled", rise_cnt, rises);

        // Silent line: TX waveform then timeout
        for (int i = 0; i < 7; i++) tx_exp_q.push_back(3 * US);
        tx_exp_q.push_back(US);
        tx_exp_q.push_back(US);
        cell_chk = 8;
        apb_write(12'h004, 32'h1);
        wait_tx_start("tx_start_silent");
        repeat (1800 + 3200 + 200) @(posedge PCLK);
        chk("tx_bits_seen", tx_exp_q.size(), 0);
        chk("tx_cells_seen", cell_chk, 0);
        apb_read(12'h004, 32'h5, "ctrl_timeout");
        apb_read(12'h000, 32'h0, "data_after_timeout");
        apb_write(12'h004, 32'h5);
        apb_read(12'h004, 32'h1, "ctrl_timeout_cleared");

        // Valid response
        done_cnt = 0;
        wait_tx_start("tx_start_resp1");
        repeat (1850) @(posedge PCLK);
        send_resp(32'h8000_0000, 1'b1);
        repeat (20) @(posedge PCLK);
        chk("poll_done_resp1", done_cnt, 1);
        apb_read(12'h000, 32'h8000_0000, "data_resp1");
        apb_read(12'h004, 32'h3, "ctrl_resp1");

        // Read while the second response is half received
        wait_tx_start("tx_start_resp2");
        repeat (1850) @(posedge PCLK);
        fork
            send_resp(32'h0000_00FF, 1'b1);
            begin
                repeat (16 * 200) @(posedge PCLK);
                apb_read(12'h000, 32'h8000_0000, "data_mid_resp2");
            end
        join
        repeat (20) @(posedge PCLK);
        chk("poll_done_resp2", done_cnt, 2);
        apb_read(12'h000, 32'h0000_00FF, "data_resp2");

        // 32 bits but no stop bit
        wait_tx_start("tx_start_nostop");
        repeat (1850) @(posedge PCLK);
        send_resp(32'h1234_5678, 1'b0);
        repeat (3200 + 300) @(posedge PCLK);
        apb_read(12'h004, 32'h7, "ctrl_nostop");
        apb_read(12'h000, 32'h0000_00FF, "data_nostop");
        chk("poll_done_nostop", done_cnt, 2);
        chk("poll_done_width", long_done, 0);
        chk("reads_pending", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
